// File: rtl/cache_mem_responder_if.sv
// Cache-side request/response bus plus the single RAM port it is arbitrated onto.
// slave is the responder's view, master is the caches'/RAM's view.
interface cache_mem_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Arbitrates the icache read port and the dcache read/write port onto one RAM port,
// holding the grantee's wait high until the RAM answers ACCESS/ERROR or the grant times out.
module cache_mem_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_mem_responder_if.slave  bus,
    output logic                  mem_err
);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1BAD1);

    typedef enum logic [1:0] {StIdle, StGrantD, StGrantI} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_d;
    logic          d_req;
    logic          fail;

    assign d_req = bus.dREN | bus.dWEN;
    assign fail  = (bus.ramstate == RAM_ERROR) || (tcnt_q == TMAX);

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        starve_d     = starve_q;
        err_d        = mem_err;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = '0;

        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (!bus.iREN) starve_d = '0;
                // Once D has won STARVE_MAX times in a row over a waiting I, I wins once.
                if (d_req && !(bus.iREN && starve_q == SMAX)) begin
                    state_d = StGrantD;
                    if (bus.iREN) starve_d = starve_q + SW'(1);
                end else if (bus.iREN) begin
                    state_d  = StGrantI;
                    starve_d = '0;
                end
            end

            StGrantD: begin
                if (!d_req) begin
                    state_d = StIdle;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (bus.ramstate == RAM_ACCESS) begin
                        bus.dwait = 1'b0;
                        if (!bus.dWEN) bus.dload = bus.ramload;
                        state_d = StIdle;
                    end else if (fail) begin
                        bus.dwait = 1'b0;
                        bus.dload = ERR_WORD;
                        err_d     = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end

            StGrantI: begin
                if (!bus.iREN) begin
                    state_d = StIdle;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == RAM_ACCESS) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        state_d   = StIdle;
                    end else if (fail) begin
                        bus.iwait = 1'b0;
                        bus.iload = ERR_WORD;
                        err_d     = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            tcnt_q   <= '0;
            starve_q <= '0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            starve_q <= starve_d;
            mem_err  <= err_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed scenarios then randomized traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_cache_mem_responder;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 8;
    localparam int unsigned SMAX = 4;
    localparam logic [31:0] BAD  = 32'hBAD1BAD1;

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic mem_err;

    cache_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_mem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_MAX(SMAX)
    ) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus.slave), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Model: who holds the RAM (0 none, 1 D, 2 I), cycles already spent in the grant,
    // consecutive D wins over a waiting I, sticky error.
    int m_gr = 0, m_cycles = 0, m_streak = 0;
    bit m_err = 0;

    bit          e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    bit          o_iwait, o_dwait, o_ren, o_wen, o_err;
    logic [31:0] o_iload, o_dload, o_addr, o_store;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int n_gr, n_cycles, n_streak;
        bit n_err, is_d, req;
        logic [31:0] v;
        @(negedge CLK);
        if (!nRST) begin
            m_gr = 0; m_cycles = 0; m_streak = 0; m_err = 0;
        end
        e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        n_gr = m_gr; n_cycles = m_cycles + 1; n_streak = m_streak; n_err = m_err;
        if (m_gr == 0) begin
            n_cycles = 0;
            if (!bus.iREN) n_streak = 0;
            if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak >= SMAX)) begin
                n_gr = 1;
                if (bus.iREN) n_streak = m_streak + 1;
            end else if (bus.iREN) begin
                n_gr = 2;
                n_streak = 0;
            end
        end else begin
            is_d = (m_gr == 1);
            req  = is_d ? (bus.dREN || bus.dWEN) : bus.iREN;
            if (!req) begin
                n_gr = 0;
            end else begin
                if (is_d) begin
                    e_addr = bus.daddr; e_store = bus.dstore;
                    e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
                end else begin
                    e_addr = bus.iaddr; e_ren = 1;
                end
                if (bus.ramstate == 2'd2 || bus.ramstate == 2'd3 || m_cycles >= TMO) begin
                    n_gr = 0;
                    if (bus.ramstate == 2'd2) v = (is_d && bus.dWEN) ? 32'h0 : bus.ramload;
                    else begin v = BAD; n_err = 1; end
                    if (is_d) begin e_dwait = 0; e_dload = v; end
                    else begin e_iwait = 0; e_iload = v; end
                end
            end
        end
        o_iwait = bus.iwait; o_dwait = bus.dwait; o_ren = bus.ramREN; o_wen = bus.ramWEN;
        o_iload = bus.iload; o_dload = bus.dload; o_addr = bus.ramaddr;
        o_store = bus.ramstore; o_err = mem_err;
        check("iwait", o_iwait, e_iwait);
        check("dwait", o_dwait, e_dwait);
        check("iload", o_iload, e_iload);
        check("dload", o_dload, e_dload);
        check("ramREN", o_ren, e_ren);
        check("ramWEN", o_wen, e_wen);
        check("ramaddr", o_addr, e_addr);
        check("ramstore", o_store, e_store);
        check("mem_err", o_err, m_err);
        @(posedge CLK);
        #1;
        if (nRST) begin
            m_gr = n_gr; m_cycles = n_cycles; m_streak = n_streak; m_err = n_err;
        end
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd1;
    endtask

    task automatic do_reset();
        nRST = 0;
        step();
        step();
        nRST = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte order[$];
        string exp_order;
        int n, pulses, r;
        exp_order = "DDDDID";
        idle_inputs();
        #1 nRST = 0;
        #2;
        step();
        nRST = 1;
        step();

        // Reset while a D grant is in progress
        bus.dREN = 1; bus.daddr = 32'h10;
        step(); step();
        nRST = 0;
        step();
        check("t1_rst_dwait", o_dwait, 1);
        check("t1_rst_ren", o_ren, 0);
        nRST = 1;
        idle_inputs();
        step();

        // I read, BUSY x3 then ACCESS
        bus.iREN = 1; bus.iaddr = 32'h40;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_busy_iwait", o_iwait, 1);
        end
        bus.ramstate = 2'd2; bus.ramload = 32'h8C220004;
        step();
        check("t2_iwait", o_iwait, 0);
        check("t2_iload", o_iload, 32'h8C220004);
        bus.iREN = 0; bus.ramstate = 2'd1;
        step();

        // Simultaneous requests: D first, IDLE, then I
        bus.iREN = 1; bus.iaddr = 32'h100; bus.dREN = 1; bus.daddr = 32'h200;
        bus.ramstate = 2'd2;
        step();
        step();
        check("t3_d_addr", o_addr, 32'h200);
        bus.dREN = 0;
        step();
        check("t3_idle_ren", o_ren, 0);
        step();
        check("t3_i_addr", o_addr, 32'h100);
        bus.iREN = 0;
        step();

        // Starvation: both held, completions must go D D D D I D
        bus.iREN = 1; bus.dREN = 1;
        for (int k = 0; k < 14; k++) begin
            step();
            if (!o_dwait) order.push_back("D");
            if (!o_iwait) order.push_back("I");
        end
        check("t4_count", (order.size() >= 6) ? 1 : 0, 1);
        for (int k = 0; k < 6 && k < order.size(); k++) check("t4_order", order[k], exp_order[k]);
        idle_inputs();
        step();

        // Write with two BUSY cycles
        bus.dWEN = 1; bus.dstore = 32'hDEADBEEF; bus.daddr = 32'h3C;
        step();
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.ramstate = 2'd2;
            step();
            check("t5_wen", o_wen, 1);
            check("t5_store", o_store, 32'hDEADBEEF);
            if (!o_dwait) pulses++;
        end
        bus.dWEN = 0; bus.ramstate = 2'd1;
        step();
        if (!o_dwait) pulses++;
        check("t5_pulses", pulses, 1);

        // Abort mid-grant
        bus.dREN = 1; step(); step();
        bus.dREN = 0; step();
        check("abort_ren", o_ren, 0);
        check("abort_dwait", o_dwait, 1);

        // Timeout with RAM held BUSY
        do_reset();
        bus.dREN = 1; bus.daddr = 32'h80;
        step();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n++;
            if (!o_dwait) break;
        end
        check("t6_tmo_cycles", n, 9);
        check("t6_tmo_dload", o_dload, BAD);
        bus.dREN = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_sticky", o_err, 1);
        end

        // ERROR response
        do_reset();
        bus.dREN = 1; step();
        bus.ramstate = 2'd3; step();
        check("t6_err_dwait", o_dwait, 0);
        check("t6_err_dload", o_dload, BAD);
        bus.dREN = 0; bus.ramstate = 2'd1; step();
        check("t6_err_flag", o_err, 1);

        // Randomized traffic
        do_reset();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            if (bus.iREN) begin
                if (!e_iwait) begin
                    bus.iREN = 1'($urandom_range(0, 1)); bus.iaddr = $urandom;
                end else if ($urandom_range(0, 31) == 0) bus.iREN = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.iREN = 1; bus.iaddr = $urandom;
            end
            if (bus.dREN || bus.dWEN) begin
                if (!e_dwait || $urandom_range(0, 31) == 0) begin
                    bus.dREN = 0; bus.dWEN = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 7);
                bus.dREN = (r == 0 || r > 3); bus.dWEN = (r <= 3);
                bus.daddr = $urandom; bus.dstore = $urandom;
            end
            r = $urandom_range(0, 15);
            if (r < 8) bus.ramstate = 2'd1;
            else if (r < 14) bus.ramstate = 2'd2;
            else if (r == 14 || c < 1500) bus.ramstate = 2'd0;
            else bus.ramstate = 2'd3;
            bus.ramload = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
